// File: rtl/diff_rx_monitor.sv
// Synchronizes, debounces and edge-detects the single-ended output of a differential receiver.
// Define DIFF_RX_MONITOR_COUNT_EN to add the saturating rise counter (cnt_clr / toggle_cnt).
module diff_rx_monitor #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int STRETCH_CYCLES  = 50000,
   parameter int CNT_W           = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             diff_in,
   input  logic             enable,
`ifdef DIFF_RX_MONITOR_COUNT_EN
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] toggle_cnt,
`endif
   output logic             level,
   output logic             rise,
   output logic             fall,
   output logic             led
);

   // state    | meaning
   // DISABLED | monitor idle, level held, no pulses
   // SEED     | one cycle: adopt the synchronized input as level, no pulse
   // STABLE   | synchronized input matches level
   // QUALIFY  | input differs from level, counting consecutive mismatches

   typedef enum logic [1:0] {
      ST_DISABLED = 2'd0,
      ST_SEED     = 2'd1,
      ST_STABLE   = 2'd2,
      ST_QUALIFY  = 2'd3
   } state_t;

   localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int STR_W = $clog2(STRETCH_CYCLES + 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
   localparam logic [STR_W-1:0] STR_LOAD = STR_W'(STRETCH_CYCLES);
   localparam logic [STR_W-1:0] STR_ONE  = STR_W'(1);

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic [DEB_W-1:0]       deb_cnt;
   logic [STR_W-1:0]       str_cnt;
   logic                   accept;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], diff_in};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // A new level is accepted on the edge that sees the final mismatching cycle.
   always_comb begin
      accept = 1'b0;
      if (enable && (s != level)) begin
         if (state == ST_STABLE) begin
            accept = (DEBOUNCE_CYCLES == 1);
         end else if (state == ST_QUALIFY) begin
            accept = (deb_cnt == DEB_LAST);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_DISABLED;
         level   <= 1'b0;
         rise    <= 1'b0;
         fall    <= 1'b0;
         deb_cnt <= '0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (!enable) begin
            state   <= ST_DISABLED;
            deb_cnt <= '0;
         end else if (accept) begin
            level   <= s;
            rise    <= s;
            fall    <= ~s;
            deb_cnt <= '0;
            state   <= ST_STABLE;
         end else begin
            case (state)
               ST_DISABLED: begin
                  deb_cnt <= '0;
                  state   <= ST_SEED;
               end
               ST_SEED: begin
                  level <= s;
                  state <= ST_STABLE;
               end
               ST_STABLE: begin
                  if (s != level) begin
                     deb_cnt <= DEB_ONE;
                     state   <= ST_QUALIFY;
                  end
               end
               ST_QUALIFY: begin
                  if (s == level) begin
                     deb_cnt <= '0;
                     state   <= ST_STABLE;
                  end else begin
                     deb_cnt <= deb_cnt + DEB_ONE;
                  end
               end
               default: begin
                  deb_cnt <= '0;
                  state   <= ST_DISABLED;
               end
            endcase
         end
      end
   end

   // Reload on every accepted edge so back-to-back activity retriggers rather than accumulates.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         str_cnt <= '0;
      end else if (accept) begin
         str_cnt <= STR_LOAD;
      end else if (str_cnt != '0) begin
         str_cnt <= str_cnt - STR_ONE;
      end
   end

   assign led = (str_cnt != '0);

`ifdef DIFF_RX_MONITOR_COUNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         toggle_cnt <= '0;
      end else if (cnt_clr) begin
         toggle_cnt <= rise ? CNT_ONE : '0;
      end else if (rise && (toggle_cnt != CNT_MAX)) begin
         toggle_cnt <= toggle_cnt + CNT_ONE;
      end
   end
`endif

endmodule
